traffic_fsm: RTL

Traffic-light phase controller for the intersection. It consumes the already-synchronized sensor, walk-request and reprogram signals and sequences the main-street, side-street and pedestrian lamps through fixed phases. Phase durations come from a runtime-programmable table. It sits directly downstream of the input synchronizer and drives the lamp outputs.

---
 rtl/traffic_fsm_pkg.sv | 26 ++
 rtl/traffic_fsm_phase_timer.sv | 45 ++++
 rtl/traffic_fsm.sv | 112 +++++++++++
 3 files changed

// File: rtl/traffic_fsm_pkg.sv
// Shared types and constants for the intersection phase controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_MAIN_GRN = 3'd0,
        ST_MAIN_YEL = 3'd1,
        ST_WALK     = 3'd2,
        ST_SIDE_GRN = 3'd3,
        ST_SIDE_YEL = 3'd4
    } state_e;

    // Lamp encodings are {R,Y,G}
    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    localparam logic [1:0] SEL_BASE = 2'd0;
    localparam logic [1:0] SEL_EXT  = 2'd1;
    localparam logic [1:0] SEL_YEL  = 2'd2;

    localparam int         DEF_TICK_DIV = 4;
    localparam logic [3:0] DEF_BASE     = 4'd6;
    localparam logic [3:0] DEF_EXT      = 4'd3;
    localparam logic [3:0] DEF_YEL      = 4'd2;

endpackage

// File: rtl/traffic_fsm_phase_timer.sv
// Tick divider plus 4-bit phase down-counter; expire marks the last cycle of a phase.
module phase_timer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       expire
);

    localparam int            DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [3:0]    rem_q, rem_d;
    logic          tick;

    assign tick   = (div_q == DIV_LAST);
    assign expire = tick && (rem_q == 4'd1);

    // A zero count only exists straight out of reset: it adopts load_val on the first tick.
    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        rem_d = rem_q;
        if (tick) begin
            rem_d = (rem_q == 4'd0) ? load_val - 4'd1 : rem_q - 4'd1;
        end
        if (load) begin
            div_d = '0;
            rem_d = load_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            rem_q <= 4'd0;
        end else begin
            div_q <= div_d;
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/traffic_fsm.sv
// Intersection phase sequencer with programmable durations.
// state | meaning: MAIN_GRN main go | MAIN_YEL main clearing | WALK pedestrians | SIDE_GRN side go | SIDE_YEL side clearing
module traffic_fsm
    import traffic_pkg::*;
#(
    parameter int         TICK_DIV   = DEF_TICK_DIV,
    parameter logic [3:0] T_BASE_DEF = DEF_BASE,
    parameter logic [3:0] T_EXT_DEF  = DEF_EXT,
    parameter logic [3:0] T_YEL_DEF  = DEF_YEL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_sync,
    input  logic       wr_sync,
    input  logic       prog_sync,
    input  logic [1:0] param_sel,
    input  logic [3:0] time_value,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_lamp
);

    state_e     state_q, state_d;
    logic       walk_pend_q, walk_pend_d;
    logic [3:0] t_base_q, t_base_d, t_ext_q, t_ext_d, t_yel_q, t_yel_d;
    logic [3:0] load_val;
    logic       load, expire;

    always_comb begin
        t_base_d = t_base_q;
        t_ext_d  = t_ext_q;
        t_yel_d  = t_yel_q;
        if (prog_sync && (time_value != 4'd0)) begin
            case (param_sel)
                SEL_BASE: t_base_d = time_value;
                SEL_EXT:  t_ext_d  = time_value;
                SEL_YEL:  t_yel_d  = time_value;
                default:  ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (prog_sync) begin
            state_d = ST_MAIN_GRN;
        end else if (expire) begin
            case (state_q)
                ST_MAIN_GRN: state_d = ST_MAIN_YEL;
                ST_MAIN_YEL: state_d = walk_pend_q ? ST_WALK : ST_SIDE_GRN;
                ST_WALK:     state_d = ST_SIDE_GRN;
                ST_SIDE_GRN: state_d = ST_SIDE_YEL;
                default:     state_d = ST_MAIN_GRN;
            endcase
        end
    end

    // Duration of the phase being entered; a write on this edge is already visible here.
    always_comb begin
        case (state_d)
            ST_MAIN_YEL, ST_SIDE_YEL: load_val = t_yel_d;
            ST_WALK:                  load_val = t_ext_d;
            ST_SIDE_GRN:              load_val = sensor_sync ? t_base_d : t_ext_d;
            default:                  load_val = t_base_d;
        endcase
    end

    assign load        = prog_sync | expire;
    assign walk_pend_d = wr_sync |
                         (walk_pend_q & ~((state_d == ST_WALK) && (state_q != ST_WALK)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_MAIN_GRN;
            walk_pend_q <= 1'b0;
            t_base_q    <= T_BASE_DEF;
            t_ext_q     <= T_EXT_DEF;
            t_yel_q     <= T_YEL_DEF;
        end else begin
            state_q     <= state_d;
            walk_pend_q <= walk_pend_d;
            t_base_q    <= t_base_d;
            t_ext_q     <= t_ext_d;
            t_yel_q     <= t_yel_d;
        end
    end

    always_comb begin
        main_light = LIGHT_RED;
        side_light = LIGHT_RED;
        walk_lamp  = 1'b0;
        case (state_q)
            ST_MAIN_GRN: main_light = LIGHT_GRN;
            ST_MAIN_YEL: main_light = LIGHT_YEL;
            ST_WALK:     walk_lamp  = 1'b1;
            ST_SIDE_GRN: side_light = LIGHT_GRN;
            ST_SIDE_YEL: side_light = LIGHT_YEL;
            default:     ;
        endcase
    end

    phase_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

endmodule
